fp32_to_u016_pipe: RTL and testbench
====================================

# fp32_to_u016_pipe

Pipelined IEEE-754 single-precision to U0.16 unsigned fractional converter with valid/ready flow control on both sides. It returns softmax probabilities, normalised in the float domain, to the fixed-point datapath. It is the inverse of the U0.16-to-fp32 conversion: every fp32 value produced from a U0.16 word converts back to that same word. Out-of-range inputs are clamped and flagged, and a saturating event counter tracks clamps for debug.

## Interface
- `CNT_W`, 16: width of the clamp event counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_fp32`  in  32  IEEE-754 single-precision operand.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  converter can accept an operand this cycle.
- `out_u016`  out  16  U0.16 result.
- `out_sat`  out  1  result was clamped to 0xFFFF (x ≥ 1.0, +Inf, or rounding overflow).
- `out_neg`  out  1  negative nonzero input, clamped to 0x0000.
- `out_nan`  out  1  NaN input, result 0x0000.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `clamp_cnt`  out  CNT_W  count of transfers with sat, neg or nan set; saturates at all-ones.
- `clamp_clr`  in  1  clears `clamp_cnt` on the next edge.

## Operation
- Conversion: result = clamp(round(x·2^16), 0, 0xFFFF).
- Field decode: s = bit 31, e = bits 30:23, m = bits 22:0.
- Classification, priority order:
  - NaN (e=255, m≠0) → 0x0000, `out_nan`.
  - s=1 and input not ±0 → 0x0000, `out_neg`.
  - e ≥ 127 (includes +Inf) → 0xFFFF, `out_sat`.
  - e=0 (zero or denormal) → 0x0000, no flag.
  - e < 110 → 0x0000, no flag.
  - Otherwise (110 ≤ e ≤ 126): q = {1, m} (24 b), shifted right by sh = 134 − e (sh in 8..24).
- Rounding: guard bit = bit sh−1 of q; sticky = OR of the bits below it.
- Rounding overflow: a rounded result of 0x10000 gives 0xFFFF and sets `out_sat`.
- -0.0 (0x80000000) → 0x0000, no flag.
- At most one flag is set per result.
- Pipeline: S1 registers the classification, the shift amount and the mantissa. S2 registers the shifted, rounded and clamped result plus the flags; S2 drives the outputs.
- Flow control: each stage advances when its successor is empty or advancing.
  - `in_ready` = !s1_valid || (!s2_valid || out_ready).
  - A transfer occurs when valid && ready on the same edge.
  - Data and flags hold stable while out_valid=1 and out_ready=0.
- Counter: increments once per output transfer with any flag set. It holds at 2^CNT_W−1.
  - `clamp_clr` wins over a simultaneous increment: the counter reads 0 after that edge.

## Timing
- Latency: 2 cycles from input transfer to out_valid, when not stalled.
- Throughput: 1 result per cycle with out_ready held high.
- Reset values:
  - s1_valid = 0, s2_valid = 0.
  - out_valid = 0, in_ready = 1 (in the first cycle after reset).
  - out_u016 = 0, all flags 0, clamp_cnt = 0.
- Reset mid-operation discards in-flight data; no output transfer completes on the reset edge.
- Full pipeline with out_ready=0: in_ready=0 and both stages hold.
- out_ready rising on a full pipe: S2 drains, S1 moves to S2 and a new input enters, all on the same edge.

## Configuration
- `FP32_TO_U016_RNE_EN` defined: round-to-nearest-even.
  - Increment when guard && (sticky || lsb).
  - e=110 can round to 0x0001.
- Undefined: truncation.
  - Guard and sticky are ignored.
  - e ≤ 110 yields 0.
  - Rounding overflow cannot occur.

## Structure
- Shared package `softmax_pkg`: FP32_BIAS=127, U016_EXP_MIN=110, U016_SHIFT_BASE=134.
- Shared package class enum: ZERO, NORM, SAT, NEG, NAN.
- One sub-module, `fp32_u016_shift_round`: combinational right-shifter plus guard/sticky/round logic, instantiated in S2.

## Test plan
- 0x3F000000 (0.5) → 0x8000, no flags, out_valid 2 cycles after transfer.
- 0x3F7FFF00 → 0xFFFF, no flag.
- 0x3F800000 → 0xFFFF with sat; 0xBF000000 → 0x0000 with neg; 0x7FC00000 → 0x0000 with nan; clamp_cnt=3.
- 0x3F7FFF80:
  - RNE: 0xFFFF with sat (rounding overflow).
  - Truncate: 0xFFFF, no flag.
- 0x37000001:
  - RNE: 0x0001.
  - Truncate: 0x0000.
  - 0x37000000 → 0x0000 in both modes.
- Round-trip sweep:
  - All 65536 U0.16 values, converted to fp32 and streamed back through the block, return unchanged.
  - Random out_ready backpressure is applied, with zero loss or duplication.
  - A reset is asserted mid-stream: out_valid=0 next cycle, clamp_cnt=0.

Source files
------------

// File: rtl/softmax_pkg.sv
// ---------------------------------------------------------------------------
// softmax_pkg
// Constants and helpers that are shared by the softmax fixed/float converters.
//   FP32_BIAS        exponent bias of IEEE-754 single precision
//   U016_EXP_MIN     smallest biased exponent that can still contribute to a
//                    U0.16 result (2^-17, the guard position of the LSB)
//   U016_SHIFT_BASE  right-shift of the 24-bit significand is
//                    U016_SHIFT_BASE - e
//   fp_class_t       operand classification carried down the pipeline
//   fp32_classify()  priority-ordered classification of an fp32 word
// ---------------------------------------------------------------------------
package softmax_pkg;

    localparam int FP32_BIAS       = 127;
    localparam int U016_EXP_MIN    = 110;
    localparam int U016_SHIFT_BASE = 134;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        SAT,
        NEG,
        NAN
    } fp_class_t;

    // Order of the tests is the priority: NaN beats sign, sign beats range.
    // -0.0 falls through to ZERO because both exponent and mantissa are zero.
    function automatic fp_class_t fp32_classify(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = x[31];
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF && m != '0)
            return NAN;
        if (s && (e != '0 || m != '0))
            return NEG;
        if (e >= 8'(FP32_BIAS))
            return SAT;
        if (e == '0)
            return ZERO;
        if (e < 8'(U016_EXP_MIN))
            return ZERO;
        return NORM;
    endfunction

endpackage

// File: rtl/fp32_to_u016_pipe_if.sv
// ---------------------------------------------------------------------------
// fp32_to_u016_pipe_if
// Valid/ready stream bundle around the fp32 -> U0.16 converter.
//   in_fp32/in_valid/in_ready     operand stream (producer -> converter)
//   out_u016/out_sat/out_neg/
//   out_nan/out_valid/out_ready   result stream (converter -> consumer)
// Modports:
//   slave   the converter's view
//   master  the surrounding datapath's view
// ---------------------------------------------------------------------------
interface fp32_to_u016_pipe_if;

    logic [31:0] in_fp32;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_u016;
    logic        out_sat;
    logic        out_neg;
    logic        out_nan;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_fp32, in_valid, out_ready,
        output in_ready, out_u016, out_sat, out_neg, out_nan, out_valid
    );

    modport master (
        output in_fp32, in_valid, out_ready,
        input  in_ready, out_u016, out_sat, out_neg, out_nan, out_valid
    );

endinterface

// File: rtl/fp32_u016_shift_round.sv
// ---------------------------------------------------------------------------
// fp32_u016_shift_round
// Combinational right shift of the 24-bit significand {1,m} into U0.16,
// followed by rounding.
//   i_mant     24-bit significand with the hidden one
//   i_sh       right-shift amount (8..24)
//   o_rounded  17-bit result; bit 16 set means the rounding carried out of
//              U0.16 and the caller must clamp
// Build option: FP32_TO_U016_RNE_EN selects round-to-nearest-even; without
// it the shifted-out bits are simply dropped (truncation).
// ---------------------------------------------------------------------------
module fp32_u016_shift_round (
    input  logic [23:0] i_mant,
    input  logic [4:0]  i_sh,
    output logic [16:0] o_rounded
);

`ifdef FP32_TO_U016_RNE_EN
    // Shift the significand inside a 48-bit window so that the bits that
    // fall off the integer part land in the low half: bit 23 is the guard
    // bit and bits 22:0 form the sticky bit.
    logic [47:0] w_wide;
    logic [16:0] w_int;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;

    assign w_wide    = {i_mant, 24'd0} >> i_sh;
    assign w_int     = 17'(w_wide >> 24);
    assign w_guard   = w_wide[23];
    assign w_sticky  = |w_wide[22:0];
    assign w_inc     = w_guard && (w_sticky || w_int[0]);
    assign o_rounded = w_int + 17'(w_inc);
`else
    // With sh >= 8 the shifted value never exceeds 0xFFFF, so no carry.
    assign o_rounded = 17'(i_mant >> i_sh);
`endif

endmodule

// File: rtl/fp32_to_u016_pipe.sv
// ---------------------------------------------------------------------------
// fp32_to_u016_pipe
// Two-stage fp32 -> U0.16 converter: result = clamp(round(x*2^16), 0, 0xFFFF).
//   S1: classification, shift amount and significand are registered.
//   S2: shifted/rounded/clamped result and flags are registered and drive
//       the outputs.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bus         stream bundle (slave modport), see fp32_to_u016_pipe_if
//   clamp_clr   clears clamp_cnt on the next edge (wins over an increment)
//   clamp_cnt   saturating count of output transfers carrying a flag
// Parameter CNT_W: clamp counter width.
// Build option: FP32_TO_U016_RNE_EN enables round-to-nearest-even (default
// build truncates).
// ---------------------------------------------------------------------------
module fp32_to_u016_pipe #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fp32_to_u016_pipe_if.slave     bus,
    input  logic                   clamp_clr,
    output logic [CNT_W-1:0]       clamp_cnt
);

    import softmax_pkg::*;

    logic             w_s1_free;
    logic             w_s2_free;
    logic             w_out_xfer;
    logic             w_any_flag;
    fp_class_t        w_cls;
    logic [4:0]       w_sh;
    logic [16:0]      w_rounded;
    logic [15:0]      w_res;
    logic             w_sat;
    logic             w_neg;
    logic             w_nan;

    logic             r_s1_valid;
    fp_class_t        r_s1_cls;
    logic [4:0]       r_s1_sh;
    logic [23:0]      r_s1_mant;

    logic             r_s2_valid;
    logic [15:0]      r_s2_data;
    logic             r_s2_sat;
    logic             r_s2_neg;
    logic             r_s2_nan;

    logic [CNT_W-1:0] r_cnt;

    // A stage may load when it is empty or its content leaves this edge.
    assign w_s2_free    = !r_s2_valid || bus.out_ready;
    assign w_s1_free    = !r_s1_valid || w_s2_free;
    assign bus.in_ready = w_s1_free;

    assign w_cls = fp32_classify(bus.in_fp32);
    // Only meaningful for NORM (e in 110..126 gives 24..8); other classes
    // ignore it, so the modular 5-bit result is harmless there.
    assign w_sh  = 5'(8'(U016_SHIFT_BASE) - bus.in_fp32[30:23]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cls   <= ZERO;
            r_s1_sh    <= '0;
            r_s1_mant  <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_cls  <= w_cls;
                r_s1_sh   <= w_sh;
                r_s1_mant <= {1'b1, bus.in_fp32[22:0]};
            end
        end
    end

    fp32_u016_shift_round u_shift_round (
        .i_mant    (r_s1_mant),
        .i_sh      (r_s1_sh),
        .o_rounded (w_rounded)
    );

    always_comb begin
        w_res = '0;
        w_sat = 1'b0;
        w_neg = 1'b0;
        w_nan = 1'b0;
        case (r_s1_cls)
            NAN:  w_nan = 1'b1;
            NEG:  w_neg = 1'b1;
            SAT: begin
                w_res = 16'hFFFF;
                w_sat = 1'b1;
            end
            NORM: begin
                // Carry out of U0.16 from rounding clamps like x >= 1.0.
                if (w_rounded[16]) begin
                    w_res = 16'hFFFF;
                    w_sat = 1'b1;
                end else begin
                    w_res = w_rounded[15:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sat   <= 1'b0;
            r_s2_neg   <= 1'b0;
            r_s2_nan   <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_sat  <= w_sat;
                r_s2_neg  <= w_neg;
                r_s2_nan  <= w_nan;
            end
        end
    end

    assign w_out_xfer = r_s2_valid && bus.out_ready;
    assign w_any_flag = r_s2_sat || r_s2_neg || r_s2_nan;

    always_ff @(posedge clk) begin
        if (rst || clamp_clr) begin
            r_cnt <= '0;
        end else if (w_out_xfer && w_any_flag && r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_u016  = r_s2_data;
    assign bus.out_sat   = r_s2_sat;
    assign bus.out_neg   = r_s2_neg;
    assign bus.out_nan   = r_s2_nan;
    assign clamp_cnt     = r_cnt;

endmodule

// File: tb/tb_fp32_to_u016_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp32_to_u016_pipe
// Directed self-checking bench for fp32_to_u016_pipe. A second instance with
// a 3-bit clamp counter exercises counter saturation in a few cycles.
// ---------------------------------------------------------------------------
module tb_fp32_to_u016_pipe;

    logic       clk;
    logic       rst;
    logic       clamp_clr;
    logic [15:0] clamp_cnt;
    logic       clamp_clr2;
    logic [2:0] clamp_cnt2;
    logic [2:0] flags_now;

    int checks   = 0;
    int failures = 0;

    fp32_to_u016_pipe_if bus_if ();
    fp32_to_u016_pipe_if bus2_if ();

    fp32_to_u016_pipe #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .clamp_clr (clamp_clr),
        .clamp_cnt (clamp_cnt)
    );

    fp32_to_u016_pipe #(.CNT_W(3)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2_if),
        .clamp_clr (clamp_clr2),
        .clamp_cnt (clamp_cnt2)
    );

    assign flags_now = {bus_if.out_sat, bus_if.out_neg, bus_if.out_nan};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // U0.16 word -> exact fp32 encoding (v / 65536).
    function automatic logic [31:0] u16_to_fp(input int v);
        int p;
        logic [31:0] r;
        if (v == 0 || v > 65535)
            return 32'h0;
        p = 15;
        while (((v >> p) & 1) == 0)
            p--;
        r[31]    = 1'b0;
        r[30:23] = 8'(111 + p);
        r[22:0]  = 23'((v << (23 - p)) & 32'h7FFFFF);
        return r;
    endfunction

    task automatic do_reset();
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_fp32   = 32'h0;
        bus_if.out_ready = 1'b1;
        clamp_clr        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One isolated conversion with out_ready high; lat counts edges from
    // the input transfer edge to the edge after which out_valid is seen.
    task automatic convert(input logic [31:0] x, output logic [15:0] d,
                           output logic [2:0] f, output int lat);
        bus_if.in_fp32   = x;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = bus_if.out_u016;
        f = flags_now;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [2:0]  f;
        int          lat;
        do_reset();
        convert(32'h3F800000, d, f, lat);
        bus_if.out_ready = 1'b0;
        bus_if.in_fp32   = 32'h3F800000;
        bus_if.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b1 || clamp_cnt !== 16'd1 || bus_if.out_u016 !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_pre: valid=%b cnt=%0d data=%h expected valid=1 cnt=1 data=ffff",
                     bus_if.out_valid, clamp_cnt, bus_if.out_u016);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
        end
        checks++;
        if (bus_if.out_u016 !== 16'h0000 || flags_now !== 3'b000) begin
            failures++;
            $display("FAIL reset_data_flags: got %h/%b expected 0000/000", bus_if.out_u016, flags_now);
        end
        checks++;
        if (clamp_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d expected 0", clamp_cnt);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_vectors();
        logic [31:0] xs [17];
        logic [15:0] ed [17];
        logic [2:0]  ef [17];
        logic [15:0] d;
        logic [2:0]  f;
        int          lat;
        int          exp_cnt;
        xs = '{32'h3F000000, 32'h3F7FFF00, 32'h3F800000, 32'hBF000000, 32'h7FC00000,
               32'h80000000, 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000001,
               32'h3E800000, 32'h37800000, 32'h36800000, 32'h37000000, 32'h38200000,
               32'hFFC00000, 32'h3F400000};
        ed = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
               16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
               16'h4000, 16'h0001, 16'h0000, 16'h0000, 16'h0002,
               16'h0000, 16'hC000};
        ef = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001,
               3'b000, 3'b100, 3'b010, 3'b000, 3'b010,
               3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
               3'b001, 3'b000};
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            convert(xs[i], d, f, lat);
            if (ef[i] != 3'b000)
                exp_cnt++;
            checks++;
            if (d !== ed[i] || f !== ef[i]) begin
                failures++;
                $display("FAIL vec_%0d x=%h: got %h flags(sat,neg,nan)=%b expected %h/%b",
                         i, xs[i], d, f, ed[i], ef[i]);
            end
            checks++;
            if (lat != 2) begin
                failures++;
                $display("FAIL vec_latency_%0d: got %0d expected 2", i, lat);
            end
            $display("vec %0d x=%h -> %h flags=%b lat=%0d", i, xs[i], d, f, lat);
        end
        checks++;
        if (clamp_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL vec_cnt: got %0d expected %0d", clamp_cnt, exp_cnt);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] xs [4];
        logic [15:0] ed [4];
        logic [2:0]  ef [4];
        logic [15:0] d;
        logic [2:0]  f;
        int          lat;
        xs = '{32'h3F7FFF80, 32'h37000001, 32'h37C00000, 32'h3F7FFFFF};
`ifdef FP32_TO_U016_RNE_EN
        ed = '{16'hFFFF, 16'h0001, 16'h0002, 16'hFFFF};
        ef = '{3'b100, 3'b000, 3'b000, 3'b100};
`else
        ed = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF};
        ef = '{3'b000, 3'b000, 3'b000, 3'b000};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            convert(xs[i], d, f, lat);
            checks++;
            if (d !== ed[i] || f !== ef[i]) begin
                failures++;
                $display("FAIL round_%0d x=%h: got %h/%b expected %h/%b",
                         i, xs[i], d, f, ed[i], ef[i]);
            end
            $display("round %0d x=%h -> %h flags=%b", i, xs[i], d, f);
        end
    endtask

    task automatic test_counter();
        logic [15:0] d;
        logic [2:0]  f;
        int          lat;
        do_reset();
        convert(32'h3F800000, d, f, lat);
        convert(32'hBF000000, d, f, lat);
        convert(32'h7FC00000, d, f, lat);
        checks++;
        if (clamp_cnt !== 16'd3) begin
            failures++;
            $display("FAIL cnt_three: got %0d expected 3", clamp_cnt);
        end
        // Clear on the same edge as a flagged output transfer.
        bus_if.in_fp32   = 32'h7FC00000;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        clamp_clr = 1'b1;
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_nan !== 1'b1) begin
            failures++;
            $display("FAIL cnt_clr_pre: valid=%b nan=%b expected 1/1", bus_if.out_valid, bus_if.out_nan);
        end
        @(posedge clk);
        #1;
        clamp_clr = 1'b0;
        checks++;
        if (clamp_cnt !== 16'd0) begin
            failures++;
            $display("FAIL cnt_clr_priority: got %0d expected 0", clamp_cnt);
        end
        convert(32'hBF800000, d, f, lat);
        checks++;
        if (clamp_cnt !== 16'd1) begin
            failures++;
            $display("FAIL cnt_after_clr: got %0d expected 1", clamp_cnt);
        end
        convert(32'h3F000000, d, f, lat);
        checks++;
        if (clamp_cnt !== 16'd1) begin
            failures++;
            $display("FAIL cnt_no_flag: got %0d expected 1", clamp_cnt);
        end
        $display("test_counter done cnt=%0d", clamp_cnt);
    endtask

    task automatic test_cnt_saturate();
        bus2_if.in_fp32   = 32'h7FC00000;
        bus2_if.out_ready = 1'b1;
        bus2_if.in_valid  = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus2_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (clamp_cnt2 !== 3'd7) begin
            failures++;
            $display("FAIL cnt_saturate: got %0d expected 7", clamp_cnt2);
        end
        clamp_clr2 = 1'b1;
        @(posedge clk);
        #1;
        clamp_clr2 = 1'b0;
        checks++;
        if (clamp_cnt2 !== 3'd0) begin
            failures++;
            $display("FAIL cnt_small_clr: got %0d expected 0", clamp_cnt2);
        end
        $display("test_cnt_saturate done");
    endtask

    task automatic test_stall();
        do_reset();
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_fp32   = 32'h3F000000;
        @(posedge clk);
        #1;
        bus_if.in_fp32 = 32'h3E800000;
        @(posedge clk);
        #1;
        bus_if.in_fp32 = 32'h3F400000;
        checks++;
        if (bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1 || bus_if.out_u016 !== 16'h8000) begin
            failures++;
            $display("FAIL stall_full: in_ready=%b valid=%b data=%h expected 0/1/8000",
                     bus_if.in_ready, bus_if.out_valid, bus_if.out_u016);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b0 || bus_if.out_u016 !== 16'h8000 || bus_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: in_ready=%b data=%h expected 0/8000", bus_if.in_ready, bus_if.out_u016);
        end
        bus_if.out_ready = 1'b1;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready: got %b expected 1", bus_if.in_ready);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        checks++;
        if (bus_if.out_u016 !== 16'h4000 || bus_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_drain_b: got %h valid=%b expected 4000/1", bus_if.out_u016, bus_if.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_u016 !== 16'hC000 || bus_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_drain_c: got %h valid=%b expected c000/1", bus_if.out_u016, bus_if.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_empty: got valid=%b expected 0", bus_if.out_valid);
        end
        $display("test_stall done");
    endtask

    task automatic test_roundtrip();
        int   send_idx;
        int   recv_idx;
        int   cyc;
        logic in_x;
        logic out_x;
        do_reset();
        send_idx = 0;
        recv_idx = 0;
        cyc      = 0;
        while (recv_idx < 65536 && cyc < 90000) begin
            bus_if.in_valid  = (send_idx < 65536);
            bus_if.in_fp32   = u16_to_fp(send_idx);
            bus_if.out_ready = ($urandom_range(0, 15) != 0);
            #1;
            in_x  = bus_if.in_valid && bus_if.in_ready;
            out_x = bus_if.out_valid && bus_if.out_ready;
            if (out_x) begin
                checks++;
                if (bus_if.out_u016 !== 16'(recv_idx) || flags_now !== 3'b000) begin
                    failures++;
                    $display("FAIL roundtrip_%0d: got %h/%b expected %h/000",
                             recv_idx, bus_if.out_u016, flags_now, 16'(recv_idx));
                end
                recv_idx++;
            end
            if (in_x)
                send_idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        checks++;
        if (recv_idx != 65536) begin
            failures++;
            $display("FAIL roundtrip_timeout: got %0d results expected 65536", recv_idx);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL roundtrip_extra: got out_valid=%b expected 0", bus_if.out_valid);
        end
        $display("test_roundtrip done results=%0d cycles=%0d", recv_idx, cyc);
    endtask

    task automatic test_midstream_reset();
        do_reset();
        bus_if.in_fp32   = 32'h7FC00000;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (clamp_cnt !== 16'd3 || bus_if.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: cnt=%0d valid=%b expected 3/1", clamp_cnt, bus_if.out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || clamp_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_flush: valid=%b cnt=%0d expected 0/0", bus_if.out_valid, clamp_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_discard: valid=%b in_ready=%b expected 0/1",
                     bus_if.out_valid, bus_if.in_ready);
        end
        $display("test_midstream_reset done");
    endtask

    initial begin
        bus2_if.in_valid  = 1'b0;
        bus2_if.in_fp32   = 32'h0;
        bus2_if.out_ready = 1'b1;
        clamp_clr2        = 1'b0;
        test_reset();
        test_vectors();
        test_rounding();
        test_counter();
        test_cnt_saturate();
        test_stall();
        test_roundtrip();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
